// File: rtl/instr_fetch_pkg.sv
// Shared fetch/decode definitions: FSM encoding, RV32I opcodes, reset PC.
// FETCH_OPCODE_CHECK_EN enables the opcode legality helper's use in fetch.
package instr_fetch_pkg;

  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  function automatic logic rv32i_legal(
    input logic [31:0] w
  );
    logic ok;
    ok = 1'b0;
    case (w[6:0])
      OPC_LUI, OPC_AUIPC, OPC_JAL,
      OPC_JALR, OPC_BRANCH, OPC_LOAD,
      OPC_STORE, OPC_OP_IMM, OPC_OP,
      OPC_MISC_MEM, OPC_SYSTEM: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok && (w[1:0] == 2'b11);
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instruction memory request/response and decode handoff.
// FETCH_OPCODE_CHECK_EN adds the id_illegal flag.
interface instr_fetch_if;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
`ifdef FETCH_OPCODE_CHECK_EN
  logic        id_illegal;
`endif

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    output id_valid,
    output id_instr,
    output id_pc,
`ifdef FETCH_OPCODE_CHECK_EN
    output id_illegal,
`endif
    input  id_ready
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data,
    input  id_valid,
    input  id_instr,
    input  id_pc,
`ifdef FETCH_OPCODE_CHECK_EN
    input  id_illegal,
`endif
    output id_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with push/pop/flush and occupancy count.
// Push while full is accepted only together with a pop.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rptr;
  logic [AW-1:0]    wptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] nxt(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push &&
                   ((count != CW'(DEPTH)) || do_pop);
  assign dout    = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= din;
        wptr      <= nxt(wptr);
      end
      if (do_pop) begin
        rptr <= nxt(rptr);
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (!do_push && do_pop) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, imem requests, response buffer, redirects.
// FETCH_OPCODE_CHECK_EN tags each buffered word with an illegal-opcode bit.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          DEPTH    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  instr_fetch_if.master        bus,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc
);

  localparam int CW = $clog2(DEPTH + 1);
`ifdef FETCH_OPCODE_CHECK_EN
  localparam int FW = 65;
`else
  localparam int FW = 64;
`endif

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [31:0]   pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] out_nxt;
  logic [CW-1:0] fifo_count;
  logic          req_valid;
  logic          fire;
  logic          rsp_acc;
  logic          push;
  logic          pop;
  logic          fifo_empty;
  logic [31:0]   pc_tag;
  logic [FW-1:0] fifo_din;
  logic [FW-1:0] fifo_dout;

  assign fire    = req_valid && bus.imem_req_ready;
  assign rsp_acc = bus.imem_rsp_valid &&
                   (outstanding != '0);
  assign push    = rsp_acc && (state == RUN) &&
                   !redirect_valid;
  assign pop     = !fifo_empty && bus.id_ready &&
                   !redirect_valid;

  // In RUN all in-flight requests are consecutive words behind pc.
  assign pc_tag  = pc - (32'(outstanding) << 2);

  always_comb begin
    out_nxt = outstanding;
    if (fire && !rsp_acc) begin
      out_nxt = outstanding + 1'b1;
    end else if (!fire && rsp_acc) begin
      out_nxt = outstanding - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    priority case (1'b1)
      redirect_valid:
        state_nxt = (out_nxt != '0) ? DRAIN : RUN;
      state == BOOT:
        state_nxt = RUN;
      state == DRAIN:
        if (out_nxt == '0) state_nxt = RUN;
      default: state_nxt = state;
    endcase
  end

  always_comb begin
    req_valid = (state == RUN) && !redirect_valid &&
                (({1'b0, outstanding} +
                  {1'b0, fifo_count}) <
                 (CW + 1)'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      outstanding <= '0;
    end else begin
      outstanding <= out_nxt;
      if (redirect_valid) begin
        pc <= redirect_pc & ~32'h3;
      end else if (fire) begin
        pc <= pc + 32'd4;
      end
    end
  end

`ifdef FETCH_OPCODE_CHECK_EN
  assign fifo_din = {!rv32i_legal(bus.imem_rsp_data),
                     bus.imem_rsp_data, pc_tag};
  assign bus.id_illegal = !fifo_empty && fifo_dout[64];
`else
  assign fifo_din = {bus.imem_rsp_data, pc_tag};
`endif

  fetch_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .flush (redirect_valid),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc;
  assign bus.id_valid       = !fifo_empty;
  assign bus.id_instr       = fifo_dout[63:32];
  assign bus.id_pc          = fifo_dout[31:0];

  // A response with nothing outstanding is a memory protocol error.
  a_rsp_expected : assert property (
    @(posedge clk) disable iff (!rst_n)
    bus.imem_rsp_valid |-> (outstanding != '0)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a variable-latency memory model.
// Covers FETCH_OPCODE_CHECK_EN checks when that macro is defined.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        ill;
  } pop_t;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  instr_fetch_if bus ();

  instr_fetch #(
    .RESET_PC (32'h0),
    .DEPTH    (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  int          nvec = 0;
  int          nerr = 0;
  int          cyc  = 0;
  int          lat  = 1;
  int          rsp_cnt = 0;
  int          rs0;
  int          bad;
  mreq_t       mq[$];
  logic [31:0] fire_q[$];
  pop_t        pop_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memword(
    input logic [31:0] a
  );
    if (a == 32'h300) return 32'h0000_0000;
    if (a == 32'h304) return 32'h0000_0013;
    return {a[19:0], 12'h013};
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // Memory and decode-side monitor, sampled at the active edge.
  always @(posedge clk) begin
    pop_t p;
    cyc++;
    if (!rst_n) begin
      mq.delete();
    end else begin
      if (bus.imem_rsp_valid) begin
        void'(mq.pop_front());
        rsp_cnt++;
      end
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        mq.push_back('{bus.imem_req_addr, cyc + lat});
        fire_q.push_back(bus.imem_req_addr);
      end
      if (bus.id_valid && bus.id_ready &&
          !redirect_valid) begin
        p.pc    = bus.id_pc;
        p.instr = bus.id_instr;
`ifdef FETCH_OPCODE_CHECK_EN
        p.ill   = bus.id_illegal;
`else
        p.ill   = 1'b0;
`endif
        pop_q.push_back(p);
      end
    end
  end

  always @(negedge clk) begin
    if (mq.size() > 0 && mq[0].due <= cyc + 1) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = memword(mq[0].addr);
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'h0;
    end
  end

  initial begin
    rst_n              = 1'b0;
    redirect_valid     = 1'b0;
    redirect_pc        = 32'h0;
    bus.imem_req_ready = 1'b1;
    bus.id_ready       = 1'b1;
    repeat (2) @(negedge clk);

    chk("rst_req_valid", 32'(bus.imem_req_valid), 0);
    chk("rst_req_addr", bus.imem_req_addr, 32'h0);
    chk("rst_id_valid", 32'(bus.id_valid), 0);
    chk("rst_id_instr", bus.id_instr, 32'h0);
    chk("rst_id_pc", bus.id_pc, 32'h0);
`ifdef FETCH_OPCODE_CHECK_EN
    chk("rst_id_illegal", 32'(bus.id_illegal), 0);
`endif

    rst_n = 1'b1;
    #1;
    chk("boot_no_req", 32'(bus.imem_req_valid), 0);
    @(negedge clk);
    chk("first_req_valid", 32'(bus.imem_req_valid), 1);
    chk("first_req_addr", bus.imem_req_addr, 32'h0);

    // Streaming at latency 1
    for (int i = 0; i < 12 && pop_q.size() < 4; i++)
      @(negedge clk);
    chk("t1_wait", 32'(pop_q.size() >= 4), 1);
    if (pop_q.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("t1_pc", pop_q[i].pc, 32'(i * 4));
        chk("t1_instr", pop_q[i].instr,
            memword(32'(i * 4)));
      end
    end

    // Decode stall: FIFO fills, requests stop
    bus.id_ready = 1'b0;
    repeat (8) @(negedge clk);
    chk("t2_req_stop", 32'(bus.imem_req_valid), 0);
    chk("t2_id_valid", 32'(bus.id_valid), 1);
    chk("t2_inflight",
        32'(fire_q.size() - pop_q.size()), 2);
    bus.id_ready = 1'b1;
    repeat (10) @(negedge clk);
    bad = 0;
    foreach (pop_q[i]) begin
      if (pop_q[i].pc !== 32'(i * 4) ||
          pop_q[i].instr !== memword(32'(i * 4)))
        bad++;
    end
    chk("t2_order", 32'(bad), 0);
    chk("t2_count", 32'(pop_q.size() >= 8), 1);

    // Redirect with full FIFO flushes it
    bus.id_ready = 1'b0;
    repeat (8) @(negedge clk);
    chk("flush_pre_valid", 32'(bus.id_valid), 1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    @(negedge clk);
    chk("flush_id_valid", 32'(bus.id_valid), 0);
    chk("flush_state", 32'(dut.state), 32'(RUN));
    redirect_valid = 1'b0;
    bus.id_ready   = 1'b1;
    lat            = 3;

    // Redirect with two in flight at latency 3
    for (int i = 0; i < 20 && mq.size() != 2; i++)
      @(negedge clk);
    chk("t3_wait_inflight", 32'(mq.size() == 2), 1);
    fire_q.delete();
    pop_q.delete();
    rs0            = rsp_cnt;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("t3_state_drain", 32'(dut.state), 32'(DRAIN));
    chk("t3_id_valid", 32'(bus.id_valid), 0);
    chk("t3_no_req", 32'(bus.imem_req_valid), 0);
    for (int i = 0; i < 20 && fire_q.size() == 0; i++)
      @(negedge clk);
    chk("t3_wait_fire", 32'(fire_q.size() > 0), 1);
    if (fire_q.size() > 0)
      chk("t3_addr", fire_q[0], 32'h100);
    chk("t3_discarded", 32'(rsp_cnt - rs0), 2);
    for (int i = 0; i < 20 && pop_q.size() == 0; i++)
      @(negedge clk);
    chk("t3_wait_pop", 32'(pop_q.size() > 0), 1);
    if (pop_q.size() > 0) begin
      chk("t3_pop_pc", pop_q[0].pc, 32'h100);
      chk("t3_pop_instr", pop_q[0].instr,
          memword(32'h100));
    end

    // Second redirect while draining
    for (int i = 0; i < 20 && mq.size() != 2; i++)
      @(negedge clk);
    chk("t4_wait_inflight", 32'(mq.size() == 2), 1);
    fire_q.delete();
    pop_q.delete();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h150;
    @(negedge clk);
    chk("t4_state_drain", 32'(dut.state), 32'(DRAIN));
    redirect_pc = 32'h200;
    @(negedge clk);
    redirect_valid = 1'b0;
    for (int i = 0; i < 20 && fire_q.size() == 0; i++)
      @(negedge clk);
    chk("t4_wait_fire", 32'(fire_q.size() > 0), 1);
    if (fire_q.size() > 0)
      chk("t4_addr", fire_q[0], 32'h200);
    for (int i = 0; i < 20 && pop_q.size() == 0; i++)
      @(negedge clk);
    chk("t4_wait_pop", 32'(pop_q.size() > 0), 1);
    if (pop_q.size() > 0)
      chk("t4_pop_pc", pop_q[0].pc, 32'h200);

    // PC wrap at the top of the address space
    lat = 1;
    fire_q.delete();
    pop_q.delete();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    for (int i = 0; i < 30 && pop_q.size() < 2; i++)
      @(negedge clk);
    chk("t5_wait", 32'(pop_q.size() >= 2), 1);
    if (fire_q.size() >= 2 && pop_q.size() >= 2) begin
      chk("t5_addr0", fire_q[0], 32'hFFFF_FFFC);
      chk("t5_addr1", fire_q[1], 32'h0);
      chk("t5_pc0", pop_q[0].pc, 32'hFFFF_FFFC);
      chk("t5_pc1", pop_q[1].pc, 32'h0);
    end

`ifdef FETCH_OPCODE_CHECK_EN
    pop_q.delete();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    @(negedge clk);
    redirect_valid = 1'b0;
    for (int i = 0; i < 30 && pop_q.size() < 2; i++)
      @(negedge clk);
    chk("t6_wait", 32'(pop_q.size() >= 2), 1);
    if (pop_q.size() >= 2) begin
      chk("t6_pc0", pop_q[0].pc, 32'h300);
      chk("t6_ill0", 32'(pop_q[0].ill), 1);
      chk("t6_ill1", 32'(pop_q[1].ill), 0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
